rr_arb_mux: RTL

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 82 ++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbiter/mux with a single registered output stage.
// MODE=0 gives fixed lowest-index priority, MODE=1 gives round robin starting after the last winner.
module rr_arb_mux #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 1,
  parameter int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] idx_s;
  logic [W-1:0]  grant_data;
  logic          any_valid;
  logic          load;
  logic          accept;
  int            idx;

  // Search downward so the candidate nearest the pointer (or index 0) is the last one written and wins.
  always_comb begin
    grant = '0;
    idx   = 0;
    idx_s = '0;
    if (MODE == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) grant = SW'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx   = (int'(ptr) + k) % N;
        idx_s = idx[SW-1:0];
        if (in_valid[idx_s]) grant = idx_s;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) grant_data = in_data[i*W +: W];
    end
  end

  assign any_valid = |in_valid;
  assign load      = !out_valid || out_ready;
  assign accept    = load && any_valid && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = accept && (grant == SW'(i));
    end
  end

  // An idle load clears out_valid but leaves the last data/index in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(N - 1);
    end else if (load) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_data <= grant_data;
        out_sel  <= grant;
        ptr      <= grant;
      end
    end
  end

endmodule
